mult_add_seq: RTL and testbench
===============================

# mult_add_seq

Sequencer that owns one fixed-point dual multiply-add datapath (two signed DATA_WIDTH products, each truncated to bits [FRAC+DATA_WIDTH-1:FRAC], then summed in DATA_WIDTH) and uses it to compute a length-`len` dot-product accumulation. Operand beats stream in over a valid/ready handshake. Each accepted beat contributes one term a1·a2 + b1·b2. The accumulated result is returned over a valid/ready output handshake. It sits between the vector operand buffers and the downstream consumer, such as normalisation/rotation stages, that needs inner products.

## Interface
- DATA_WIDTH, 20, operand/term/accumulator width (signed, two's complement)
- FRAC, 16, fractional bits; product slice is [FRAC+DATA_WIDTH-1:FRAC]
- LEN_W, 5, width of `len` (max 2^LEN_W-1 beats)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a job; sampled only in IDLE
- len  in  LEN_W  beat count for the job, latched with `start`
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a1, a2, b1, b2  in  DATA_WIDTH each  signed operands of the current beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_WIDTH  accumulated result (signed)
- out_ovf  out  1  sticky: signed overflow occurred in any accumulator add of this job
- busy  out  1  state != IDLE

## Operation
- Term per beat: p0 = a1·a2 (2·DATA_WIDTH signed), p1 = b1·b2. term = p0[FRAC+:DATA_WIDTH] + p1[FRAC+:DATA_WIDTH], sum wraps modulo 2^DATA_WIDTH. Truncation is floor (no rounding). Term wrap is not flagged.
- Accumulator: acc <= acc + term, wraps modulo 2^DATA_WIDTH. Overflow occurs when acc and term have equal sign and the sum's sign differs. Overflow sets `out_ovf`, which stays set until the next `start`.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE → RUN on `start` with len≠0: latch len into remaining counter, clear acc, term-valid and ovf.
  - IDLE → DONE on `start` with len=0: acc=0, ovf=0.
  - RUN: in_ready=1. Each in_valid&&in_ready loads the term register, sets term-valid and decrements remaining. The accept that brings remaining to 0 moves the FSM to FLUSH.
  - FLUSH: in_ready=0. Pending term accumulates; → DONE.
  - DONE: out_valid=1, out_data=acc, out_ovf valid. On out_ready → IDLE.
- The term register adds into acc on the edge after it is loaded, in RUN and FLUSH alike. Back-to-back beats sustain 1 beat/cycle.
- `start` outside IDLE is ignored. `len` and operand changes outside a handshake have no effect.
- In-job `in_valid` gaps stall only the counter; the pending term still drains.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_ovf=0, busy=0, acc=0, counter=0, term-valid=0.
- Reset asserted mid-job aborts immediately (async). Nothing is retained, and the next `start` behaves as from power-up.
- busy rises the cycle after the `start` edge.
- Last beat accepted at edge k: term registered at k, acc final at k+1, out_valid=1 from edge k+1 onward.
- len=0: out_valid=1 from the edge after the `start` edge.
- out_data/out_ovf hold stable while out_valid=1 and out_ready=0.
- Result handshake at edge m: out_valid=0 and busy=0 after m. A `start` is honoured earliest at edge m+1.
- in_ready is combinational from state only (no dependence on in_valid).

## Test plan
- Basic: len=1, a1=a2=0x10000 (1.0), b1=b2=0x08000 (0.5). Expect out_data=0x14000 (1.25), out_ovf=0, out_valid from 2nd edge after accept.
- Gapped stream: len=4, in_valid toggling 1,0,1,1,0,1. Each beat has a1=0x20000, a2=0x08000, b=0. Expect exactly 4 accepts, in_ready=0 after the 4th, out_data=0x40000.
- Floor truncation: len=1, a1=0xFFFFF (−1 LSB), a2=0x00001, b=0. Expect out_data=0xFFFFF.
- Overflow wrap: len=2, each beat a1=0x30000, a2=0x20000, b=0 (term 6.0). Expect out_data=0xC0000 (−4.0), out_ovf=1. A following job with small positive terms must report out_ovf=0.
- Control corners:
  - len=0 gives out_valid the edge after start, with out_data=0.
  - start pulsed during RUN is ignored (beat count unchanged).
  - out_ready held low 5 cycles leaves out_data stable and busy=1.
- Reset mid-RUN after 2 of 4 beats: all outputs return to reset values at once. A new len=1 job (1.0·1.0) then gives out_data=0x10000.

Source files
------------

// File: rtl/mult_add_seq_if.sv
// mult_add_seq_if
// Bundles the job control, operand stream and result stream of the
// dot-product sequencer.
//   master : drives start/len, operand beats (in_valid, a1, a2, b1, b2)
//            and out_ready; observes in_ready, out_valid, out_data,
//            out_ovf and busy.
//   slave  : the sequencer side (mirror of master).
interface mult_add_seq_if #(
  parameter int DATA_WIDTH = 20,
  parameter int LEN_W      = 5
);
  logic                         start;
  logic        [LEN_W-1:0]      len;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] a1;
  logic signed [DATA_WIDTH-1:0] a2;
  logic signed [DATA_WIDTH-1:0] b1;
  logic signed [DATA_WIDTH-1:0] b2;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_ovf;
  logic                         busy;

  modport master (
    output start, len, in_valid, a1, a2, b1, b2, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, a1, a2, b1, b2, out_ready,
    output in_ready, out_valid, out_data, out_ovf, busy
  );
endinterface

// File: rtl/mult_add_seq.sv
// mult_add_seq
// Dot-product sequencer around one fixed-point dual multiply-add.
// Each accepted operand beat contributes a1*a2 + b1*b2 (products floored
// to DATA_WIDTH bits at the FRAC binary point, summed with wrap) into a
// wrapping accumulator; the result is returned over a valid/ready
// handshake with a sticky signed-overflow flag.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mult_add_seq_if.slave (start/len, operand stream,
//          result stream, busy)
module mult_add_seq #(
  parameter int DATA_WIDTH = 20,
  parameter int FRAC       = 16,
  parameter int LEN_W      = 5
) (
  input  logic          clk,
  input  logic          rst,
  mult_add_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed product floored at the binary point: taking the bit slice of
  // the two's complement product is floor division by 2^FRAC.
  function automatic logic signed [DATA_WIDTH-1:0] trunc_mul(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = x * y;
    return p[FRAC +: DATA_WIDTH];
  endfunction

  // Signed overflow of a wrapping add: operands agree in sign, sum does not.
  function automatic logic add_ovf(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [DATA_WIDTH-1:0] y,
    input logic signed [DATA_WIDTH-1:0] s
  );
    return (x[DATA_WIDTH-1] == y[DATA_WIDTH-1]) &&
           (s[DATA_WIDTH-1] != x[DATA_WIDTH-1]);
  endfunction

  state_t                       state;
  logic        [LEN_W-1:0]      remaining;
  logic                         vld_p0;
  logic signed [DATA_WIDTH-1:0] term_p0;
  logic signed [DATA_WIDTH-1:0] acc_p1;
  logic                         ovf;
  logic                         out_valid_r;
  logic                         busy_r;

  logic                         accept;
  logic signed [DATA_WIDTH-1:0] term_calc;
  logic signed [DATA_WIDTH-1:0] acc_sum;

  assign bus.in_ready  = (state == RUN);
  assign accept        = bus.in_valid && (state == RUN);
  assign term_calc     = trunc_mul(bus.a1, bus.a2) + trunc_mul(bus.b1, bus.b2);
  assign acc_sum       = acc_p1 + term_p0;

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = acc_p1;
  assign bus.out_ovf   = ovf;
  assign bus.busy      = busy_r;

  // Stage p0: term register, loaded only on an accepted beat
  always_ff @(posedge clk) begin
    if (accept) begin
      term_p0 <= term_calc;
    end
  end

  // Stage p1: accumulate pending term; sequencing FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      vld_p0      <= 1'b0;
      acc_p1      <= '0;
      ovf         <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (vld_p0) begin
        acc_p1 <= acc_sum;
        if (add_ovf(acc_p1, term_p0, acc_sum)) begin
          ovf <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc_p1 <= '0;
            ovf    <= 1'b0;
            vld_p0 <= 1'b0;
            busy_r <= 1'b1;
            if (bus.len == '0) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              remaining <= bus.len;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          vld_p0 <= accept;
          if (accept) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          vld_p0      <= 1'b0;
          state       <= DONE;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_add_seq.sv
module tb_mult_add_seq;
  localparam int DW   = 20;
  localparam int FRAC = 16;
  localparam int LW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_add_seq_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

  mult_add_seq #(.DATA_WIDTH(DW), .FRAC(FRAC), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] op_a1 [32];
  logic [DW-1:0] op_a2 [32];
  logic [DW-1:0] op_b1 [32];
  logic [DW-1:0] op_b2 [32];
  bit            vpat  [16];
  int            vpat_len;

  // results of the last run_job
  logic [DW-1:0] r_data;
  logic          r_ovf;
  int            r_acc;
  int            r_lat;
  bit            r_busy_start, r_valid_start, r_ready_after_last;
  bit            r_stable, r_post_valid, r_post_busy, r_timeout;

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [DW-1:0] v);
    return {{(64-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic [DW-1:0] wrap(input longint v);
    return v[DW-1:0];
  endfunction

  function automatic void model(input int n, output logic [DW-1:0] d, output logic o);
    longint acc;
    longint t;
    longint s;
    acc = 0;
    o   = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = ((sx(op_a1[i]) * sx(op_a2[i])) >>> FRAC) + ((sx(op_b1[i]) * sx(op_b2[i])) >>> FRAC);
      t = sx(wrap(t));
      s = acc + t;
      if (s > 524287 || s < -524288) o = 1'b1;
      acc = sx(wrap(s));
    end
    d = wrap(acc);
  endfunction

  // ---------------- stimulus ----------------
  task automatic set_op(input int i, input logic [DW-1:0] x1, input logic [DW-1:0] x2,
                        input logic [DW-1:0] y1, input logic [DW-1:0] y2);
    op_a1[i] = x1; op_a2[i] = x2; op_b1[i] = y1; op_b2[i] = y2;
  endtask

  // mode 0: in_valid always high, 1: random, 2: vpat pattern then high
  task automatic run_job(input int n, input int mode, input int hold, input bit spurious);
    int  idx;
    int  cyc;
    int  last;
    bit  v;
    bit  hs;
    logic [DW-1:0] d0;
    logic          o0;
    bus.start = 1'b1;
    bus.len   = LW'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = LW'($urandom);
    r_busy_start  = bus.busy;
    r_valid_start = bus.out_valid;
    idx = 0; cyc = 0; last = -1; r_acc = 0; r_lat = -1;
    r_ready_after_last = 1'b1; r_timeout = 1'b0;
    while (!bus.out_valid) begin
      if (cyc > 200) begin
        r_timeout = 1'b1;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = (cyc < vpat_len) ? vpat[cyc] : 1'b1;
      endcase
      bus.in_valid = v;
      if (idx < 32) begin
        bus.a1 = op_a1[idx]; bus.a2 = op_a2[idx]; bus.b1 = op_b1[idx]; bus.b2 = op_b2[idx];
      end else begin
        bus.a1 = DW'($urandom); bus.a2 = DW'($urandom);
        bus.b1 = DW'($urandom); bus.b2 = DW'($urandom);
      end
      bus.start = spurious;
      bus.len   = '1;
      hs = v && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        idx++;
        r_acc++;
        if (idx == n) begin
          last = cyc;
          r_ready_after_last = bus.in_ready;
        end
      end
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    if (last >= 0) r_lat = cyc - last;
    d0 = bus.out_data;
    o0 = bus.out_ovf;
    r_data   = d0;
    r_ovf    = o0;
    r_stable = 1'b1;
    bus.out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.out_data !== d0 || bus.out_ovf !== o0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1)
        r_stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    r_post_valid = bus.out_valid;
    r_post_busy  = bus.busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 20'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000", bus.out_data); end
    checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", bus.out_ovf); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    set_op(0, 20'h10000, 20'h10000, 20'h08000, 20'h08000);
    run_job(1, 0, 0, 1'b0);
    checks++; if (r_busy_start !== 1'b1) begin failures++; $display("FAIL basic_busy_after_start got=%b exp=1", r_busy_start); end
    checks++; if (r_data !== 20'h14000) begin failures++; $display("FAIL basic_data got=%h exp=14000", r_data); end
    checks++; if (r_ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", r_ovf); end
    checks++; if (r_lat !== 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", r_lat); end
    checks++; if (r_post_valid !== 1'b0 || r_post_busy !== 1'b0) begin failures++; $display("FAIL basic_after_handshake got=%b%b exp=00", r_post_valid, r_post_busy); end
  endtask

  task automatic test_gapped;
    logic [DW-1:0] ed; logic eo;
    for (int i = 0; i < 4; i++) set_op(i, 20'h20000, 20'h08000, 20'h0, 20'h0);
    vpat[0] = 1; vpat[1] = 0; vpat[2] = 1; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1;
    vpat_len = 6;
    run_job(4, 2, 0, 1'b0);
    model(4, ed, eo);
    checks++; if (r_acc !== 4) begin failures++; $display("FAIL gapped_accepts got=%0d exp=4", r_acc); end
    checks++; if (r_ready_after_last !== 1'b0) begin failures++; $display("FAIL gapped_in_ready_after_last got=%b exp=0", r_ready_after_last); end
    checks++; if (r_data !== 20'h40000 || r_data !== ed) begin failures++; $display("FAIL gapped_data got=%h exp=40000", r_data); end
  endtask

  task automatic test_floor;
    set_op(0, 20'hFFFFF, 20'h00001, 20'h0, 20'h0);
    run_job(1, 0, 0, 1'b0);
    checks++; if (r_data !== 20'hFFFFF) begin failures++; $display("FAIL floor_data got=%h exp=fffff", r_data); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 2; i++) set_op(i, 20'h30000, 20'h20000, 20'h0, 20'h0);
    run_job(2, 0, 0, 1'b0);
    checks++; if (r_data !== 20'hC0000) begin failures++; $display("FAIL ovf_data got=%h exp=c0000", r_data); end
    checks++; if (r_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", r_ovf); end
    for (int i = 0; i < 3; i++) set_op(i, 20'h01000, 20'h10000, 20'h00800, 20'h10000);
    run_job(3, 0, 0, 1'b0);
    checks++; if (r_ovf !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", r_ovf); end
    checks++; if (r_data !== 20'h04800) begin failures++; $display("FAIL ovf_next_data got=%h exp=04800", r_data); end
  endtask

  task automatic test_len0;
    run_job(0, 0, 0, 1'b0);
    checks++; if (r_valid_start !== 1'b1) begin failures++; $display("FAIL len0_valid got=%b exp=1", r_valid_start); end
    checks++; if (r_data !== 20'h0 || r_ovf !== 1'b0) begin failures++; $display("FAIL len0_data got=%h/%b exp=00000/0", r_data, r_ovf); end
  endtask

  task automatic test_spurious_start;
    logic [DW-1:0] ed; logic eo;
    for (int i = 0; i < 3; i++) set_op(i, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    run_job(3, 1, 0, 1'b1);
    model(3, ed, eo);
    checks++; if (r_acc !== 3) begin failures++; $display("FAIL spurious_accepts got=%0d exp=3", r_acc); end
    checks++; if (r_data !== ed || r_ovf !== eo) begin failures++; $display("FAIL spurious_data got=%h/%b exp=%h/%b", r_data, r_ovf, ed, eo); end
  endtask

  task automatic test_hold;
    set_op(0, 20'h18000, 20'h10000, 20'h0, 20'h0);
    run_job(1, 0, 5, 1'b0);
    checks++; if (r_stable !== 1'b1) begin failures++; $display("FAIL hold_stable got=%b exp=1", r_stable); end
    checks++; if (r_data !== 20'h18000) begin failures++; $display("FAIL hold_data got=%h exp=18000", r_data); end
    checks++; if (r_post_valid !== 1'b0 || r_post_busy !== 1'b0) begin failures++; $display("FAIL hold_release got=%b%b exp=00", r_post_valid, r_post_busy); end
  endtask

  task automatic test_reset_mid;
    bus.start = 1'b1; bus.len = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a1 = 20'h10000; bus.a2 = 20'h10000; bus.b1 = 20'h0; bus.b2 = 20'h0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_data !== 20'h20000) begin failures++; $display("FAIL mid_acc_before_reset got=%h exp=20000", bus.out_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset_ctrl got=%b%b%b exp=000", bus.in_ready, bus.busy, bus.out_valid); end
    checks++; if (bus.out_data !== 20'h0 || bus.out_ovf !== 1'b0) begin
      failures++; $display("FAIL mid_reset_data got=%h/%b exp=00000/0", bus.out_data, bus.out_ovf); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    set_op(0, 20'h10000, 20'h10000, 20'h0, 20'h0);
    run_job(1, 0, 0, 1'b0);
    checks++; if (r_data !== 20'h10000 || r_acc !== 1) begin failures++; $display("FAIL mid_next_job got=%h/%0d exp=10000/1", r_data, r_acc); end
  endtask

  task automatic test_random;
    logic [DW-1:0] ed; logic eo;
    int n;
    int h;
    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(1, 10);
      h = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        if (j % 2 == 0)
          set_op(i, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
        else
          set_op(i, DW'(sx(17'($urandom))), DW'(sx(17'($urandom))), DW'(sx(17'($urandom))), DW'(sx(17'($urandom))));
      end
      run_job(n, 1, h, 1'b0);
      model(n, ed, eo);
      checks++; if (r_timeout !== 1'b0 || r_acc !== n) begin failures++; $display("FAIL rand_accepts job=%0d got=%0d exp=%0d timeout=%b", j, r_acc, n, r_timeout); end
      checks++; if (r_data !== ed || r_ovf !== eo) begin failures++; $display("FAIL rand_result job=%0d got=%h/%b exp=%h/%b", j, r_data, r_ovf, ed, eo); end
      checks++; if (r_lat !== 1 || r_stable !== 1'b1) begin failures++; $display("FAIL rand_timing job=%0d lat=%0d stable=%b exp=1/1", j, r_lat, r_stable); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.a1 = '0; bus.a2 = '0; bus.b1 = '0; bus.b2 = '0;
    bus.out_ready = 1'b0;
    vpat_len = 0;
    test_reset;
    test_basic;
    test_gapped;
    test_floor;
    test_overflow;
    test_len0;
    test_spurious_start;
    test_hold;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
